// File: rtl/move_select_if.sv
`default_nettype none
// ============================================================================
//  Module      : move_select_if
//  Description : Bundle between the move selector and its neighbours.
//                Carries the scanner weight-write port, the turn commands,
//                the shared board read port and the selected-move results.
//                The "master" modport is the environment side: scanners,
//                turn controller and board memory. The "slave" modport is
//                the selector itself.
//  Ports       : enaWRITE/XlocV/YlocV/weight   weight write into score map
//                clearMap/enaSelect            turn commands (IDLE only)
//                enaRead/boardX/boardY         board read request
//                boardDataIN                   board cell contents
//                busy/moveValid/noMove         status and result strobes
//                moveX/moveY/bestScore         selected move, held
//  Revision    : 1.0  initial release
// ============================================================================
interface move_select_if #(
    parameter int SW = 8
);
    logic          enaWRITE;
    logic [4:0]    XlocV;
    logic [4:0]    YlocV;
    logic [3:0]    weight;
    logic          clearMap;
    logic          enaSelect;
    logic [1:0]    boardDataIN;
    logic          enaRead;
    logic [4:0]    boardX;
    logic [4:0]    boardY;
    logic          busy;
    logic          moveValid;
    logic          noMove;
    logic [4:0]    moveX;
    logic [4:0]    moveY;
    logic [SW-1:0] bestScore;

    modport master (
        output enaWRITE, XlocV, YlocV, weight, clearMap, enaSelect, boardDataIN,
        input  enaRead, boardX, boardY, busy, moveValid, noMove, moveX, moveY, bestScore
    );

    modport slave (
        input  enaWRITE, XlocV, YlocV, weight, clearMap, enaSelect, boardDataIN,
        output enaRead, boardX, boardY, busy, moveValid, noMove, moveX, moveY, bestScore
    );
endinterface
`default_nettype wire

// File: rtl/move_select.sv
`default_nettype none
// ============================================================================
//  Module      : move_select
//  Description : Accumulates scanner weights into a BRD x BRD score map and,
//                on command, scans the board in raster order for the
//                highest-scoring empty cell. Ties go to the earliest cell.
//                The map is zeroed after reset and on every clearMap.
//  Ports       : clk    single rising-edge clock
//                reset  asynchronous, active-low
//                bus    move_select_if.slave (write port, commands, board
//                       read port, move results)
//  Revision    : 1.0  initial release
// ============================================================================
module move_select #(
    parameter int BRD = 19,
    parameter int SW  = 8
) (
    input  wire logic     clk,
    input  wire logic     reset,
    move_select_if.slave  bus
);

    localparam int            c_CELLS    = BRD * BRD;
    localparam logic [8:0]    c_LAST_IDX = 9'(c_CELLS - 1);
    localparam logic [4:0]    c_LAST_XY  = 5'(BRD - 1);
    localparam logic [8:0]    c_BRD9     = 9'(BRD);
    localparam logic [SW-1:0] c_MAX      = '1;
    localparam logic [3:0]    c_THREAT   = 4'd8;
    localparam logic [1:0]    c_EMPTY    = 2'd2;

    typedef enum logic [2:0] {
        CLEAR    = 3'd0,
        IDLE     = 3'd1,
        SEL_ADRS = 3'd2,
        SEL_READ = 3'd3,
        DONE     = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_q,     state_d;
    logic [8:0]    clr_q,       clr_d;
    logic [4:0]    selX_q,      selX_d;
    logic [4:0]    selY_q,      selY_d;
    logic          found_q,     found_d;
    logic [SW-1:0] best_q,      best_d;
    logic [4:0]    bestX_q,     bestX_d;
    logic [4:0]    bestY_q,     bestY_d;
    logic [4:0]    moveX_q,     moveX_d;
    logic [4:0]    moveY_q,     moveY_d;
    logic [SW-1:0] bestScore_q, bestScore_d;
    logic          moveValid_q, moveValid_d;
    logic          noMove_q,    noMove_d;

    // Score map: no reset, CLEAR walks every cell to zero instead.
    logic [SW-1:0] map_q [c_CELLS];

    // ------------------------------------------------------------------
    // Map read ports and accumulate datapath
    // ------------------------------------------------------------------
    logic [8:0]    w_wr_addr;
    logic [8:0]    w_sel_addr;
    logic [SW-1:0] w_wr_cell;
    logic [SW-1:0] w_sel_cell;
    logic          w_wr_ok;
    logic [SW:0]   w_sum;
    logic [SW-1:0] w_acc;

    assign w_wr_addr  = 9'(bus.YlocV) * c_BRD9 + 9'(bus.XlocV);
    assign w_sel_addr = 9'(selY_q) * c_BRD9 + 9'(selX_q);
    assign w_wr_cell  = map_q[w_wr_addr];
    assign w_sel_cell = map_q[w_sel_addr];

    // Off-board coordinates would alias onto other cells, so they are dropped.
    assign w_wr_ok = bus.enaWRITE && (bus.XlocV <= c_LAST_XY) && (bus.YlocV <= c_LAST_XY);

    // One extra bit catches overflow so the score clamps instead of wrapping.
    assign w_sum = {1'b0, w_wr_cell} + (SW+1)'(bus.weight);
    assign w_acc = (bus.weight == c_THREAT) ? c_MAX :
                   (w_sum[SW]               ? c_MAX : w_sum[SW-1:0]);

    // Single map write port shared by CLEAR and IDLE accumulation.
    logic          w_we;
    logic [8:0]    w_wa;
    logic [SW-1:0] w_wd;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        selX_d      = selX_q;
        selY_d      = selY_q;
        found_d     = found_q;
        best_d      = best_q;
        bestX_d     = bestX_q;
        bestY_d     = bestY_q;
        moveX_d     = moveX_q;
        moveY_d     = moveY_q;
        bestScore_d = bestScore_q;
        moveValid_d = 1'b0;
        noMove_d    = 1'b0;
        w_we        = 1'b0;
        w_wa        = clr_q;
        w_wd        = '0;

        case (state_q)
            CLEAR: begin
                w_we = 1'b1;
                w_wa = clr_q;
                w_wd = '0;
                if (clr_q == c_LAST_IDX) begin
                    clr_d   = '0;
                    state_d = IDLE;
                end else begin
                    clr_d = clr_q + 9'd1;
                end
            end

            IDLE: begin
                // A write alongside a command still lands this edge.
                if (w_wr_ok) begin
                    w_we = 1'b1;
                    w_wa = w_wr_addr;
                    w_wd = w_acc;
                end
                if (bus.clearMap) begin
                    clr_d   = '0;
                    state_d = CLEAR;
                end else if (bus.enaSelect) begin
                    selX_d  = '0;
                    selY_d  = '0;
                    found_d = 1'b0;
                    best_d  = '0;
                    bestX_d = '0;
                    bestY_d = '0;
                    state_d = SEL_ADRS;
                end
            end

            SEL_ADRS: begin
                state_d = SEL_READ;
            end

            SEL_READ: begin
                // Strict compare keeps the earliest raster cell on a tie.
                if ((bus.boardDataIN == c_EMPTY) && (!found_q || (w_sel_cell > best_q))) begin
                    found_d = 1'b1;
                    best_d  = w_sel_cell;
                    bestX_d = selX_q;
                    bestY_d = selY_q;
                end
                if (selX_q == c_LAST_XY) begin
                    if (selY_q == c_LAST_XY) begin
                        state_d = DONE;
                    end else begin
                        selX_d  = '0;
                        selY_d  = selY_q + 5'd1;
                        state_d = SEL_ADRS;
                    end
                end else begin
                    selX_d  = selX_q + 5'd1;
                    state_d = SEL_ADRS;
                end
            end

            DONE: begin
                // First cycle raises the result pulse; the second cycle, with
                // the pulse visible and busy still high, returns to IDLE.
                if (moveValid_q || noMove_q) begin
                    state_d = IDLE;
                end else if (found_q) begin
                    moveValid_d = 1'b1;
                    moveX_d     = bestX_q;
                    moveY_d     = bestY_q;
                    bestScore_d = best_q;
                end else begin
                    noMove_d = 1'b1;
                end
            end

            default: begin
                clr_d   = '0;
                state_d = CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR;
            clr_q       <= '0;
            selX_q      <= '0;
            selY_q      <= '0;
            found_q     <= 1'b0;
            best_q      <= '0;
            bestX_q     <= '0;
            bestY_q     <= '0;
            moveX_q     <= '0;
            moveY_q     <= '0;
            bestScore_q <= '0;
            moveValid_q <= 1'b0;
            noMove_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            selX_q      <= selX_d;
            selY_q      <= selY_d;
            found_q     <= found_d;
            best_q      <= best_d;
            bestX_q     <= bestX_d;
            bestY_q     <= bestY_d;
            moveX_q     <= moveX_d;
            moveY_q     <= moveY_d;
            bestScore_q <= bestScore_d;
            moveValid_q <= moveValid_d;
            noMove_q    <= noMove_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            map_q[w_wa] <= w_wd;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic w_reading;
    assign w_reading = (state_q == SEL_ADRS) || (state_q == SEL_READ);

    assign bus.enaRead   = w_reading;
    assign bus.boardX    = w_reading ? selX_q : 5'd0;
    assign bus.boardY    = w_reading ? selY_q : 5'd0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.moveValid = moveValid_q;
    assign bus.noMove    = noMove_q;
    assign bus.moveX     = moveX_q;
    assign bus.moveY     = moveY_q;
    assign bus.bestScore = bestScore_q;

endmodule
`default_nettype wire

// File: tb/tb_move_select.sv
`default_nettype none
// ============================================================================
//  Module      : tb_move_select
//  Description : Self-checking bench for move_select. Expected selection
//                results are queued when a selection is started; a monitor
//                pops and compares whenever moveValid or noMove pulses.
//                The board memory model answers read requests one cycle
//                after the address is presented.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_move_select;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    move_select_if #(.SW(8)) bus ();

    move_select #(.BRD(19), .SW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Board model: 0 black, 1 white, 2 empty, 3 occupied.
    logic [1:0] board [19][19];

    always @(posedge clk) begin
        if (bus.enaRead && bus.boardX <= 5'd18 && bus.boardY <= 5'd18)
            bus.boardDataIN <= board[bus.boardY][bus.boardX];
        else
            bus.boardDataIN <= 2'd3;
    end

    typedef struct {
        bit is_move;
        int x;
        int y;
        int score;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every result strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && (bus.moveValid || bus.noMove)) begin
            exp_t e;
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_result: moveValid=%0d noMove=%0d move=(%0d,%0d) score=%0d",
                         bus.moveValid, bus.noMove, bus.moveX, bus.moveY, bus.bestScore);
            end else begin
                e = sb.pop_front();
                if (bus.moveValid !== e.is_move || bus.noMove !== !e.is_move ||
                    int'(bus.moveX) != e.x || int'(bus.moveY) != e.y ||
                    int'(bus.bestScore) != e.score) begin
                    n_errors++;
                    $display("FAIL result: got mv=%0d nm=%0d (%0d,%0d) score=%0d expected mv=%0d (%0d,%0d) score=%0d",
                             bus.moveValid, bus.noMove, bus.moveX, bus.moveY, bus.bestScore,
                             e.is_move, e.x, e.y, e.score);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_board(input logic [1:0] v);
        for (int y = 0; y < 19; y++)
            for (int x = 0; x < 19; x++)
                board[y][x] = v;
    endtask

    task automatic wr(input int x, input int y, input int w);
        bus.enaWRITE = 1'b1;
        bus.XlocV    = 5'(x);
        bus.YlocV    = 5'(y);
        bus.weight   = 4'(w);
        tick();
        bus.enaWRITE = 1'b0;
    endtask

    // Wait for busy to drop; returns the number of edges waited.
    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic do_clear(input string name);
        int n;
        bus.clearMap = 1'b1;
        tick();
        bus.clearMap = 1'b0;
        check({name, "_busy"}, int'(bus.busy), 1);
        wait_idle(n);
        check({name, "_clear_cycles"}, n, 361);
    endtask

    task automatic do_select(input string name, input bit mv, input int x, input int y, input int s);
        int n;
        exp_t e;
        e.is_move = mv; e.x = x; e.y = y; e.score = s;
        sb.push_back(e);
        bus.enaSelect = 1'b1;
        tick();
        bus.enaSelect = 1'b0;
        n = 0;
        while (!(bus.moveValid || bus.noMove) && n < 1000) begin
            tick();
            n++;
            if (n == 100) check({name, "_enaRead"}, int'(bus.enaRead), 1);
        end
        check({name, "_latency"}, n, 723);
        check({name, "_busy_at_pulse"}, int'(bus.busy), 1);
        tick();
        check({name, "_idle_after"}, int'(bus.busy), 0);
    endtask

    initial begin
        int n;
        bus.enaWRITE  = 1'b0;
        bus.XlocV     = '0;
        bus.YlocV     = '0;
        bus.weight    = '0;
        bus.clearMap  = 1'b0;
        bus.enaSelect = 1'b0;
        fill_board(2'd2);
        reset = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",      int'(bus.busy),      1);
        check("rst_enaRead",   int'(bus.enaRead),   0);
        check("rst_boardX",    int'(bus.boardX),    0);
        check("rst_moveValid", int'(bus.moveValid), 0);
        check("rst_noMove",    int'(bus.noMove),    0);
        check("rst_moveXY",    int'({bus.moveX, bus.moveY}), 0);
        check("rst_bestScore", int'(bus.bestScore), 0);
        reset = 1'b1;
        wait_idle(n);
        check("rst_clear_cycles", n, 361);

        // All-zero map on an empty board picks the first cell
        do_select("sel_zero", 1'b1, 0, 0, 0);

        // Writes and commands during CLEAR are dropped
        bus.clearMap = 1'b1;
        tick();
        bus.clearMap = 1'b0;
        repeat (3) tick();
        wr(2, 2, 8);
        bus.enaSelect = 1'b1;
        tick();
        bus.enaSelect = 1'b0;
        wait_idle(n);
        check("clr_drop_idle", int'(bus.busy), 0);

        // Saturating accumulation, back-to-back to one cell
        for (int i = 0; i < 60; i++) wr(3, 4, 5);
        do_select("sel_sat", 1'b1, 3, 4, 255);

        // Threat code and clamping after threat
        do_clear("clr2");
        wr(10, 7, 2);
        wr(10, 7, 8);
        wr(10, 7, 3);
        wr(0, 0, 7);
        do_select("sel_threat", 1'b1, 10, 7, 255);
        // Threat alone gives 255; the earlier raster cell wins the tie
        wr(12, 0, 8);
        do_select("sel_threat2", 1'b1, 12, 0, 255);

        // Ties, occupancy and off-board coordinates
        do_clear("clr3");
        wr(5, 2, 6);
        wr(1, 9, 6);
        wr(7, 7, 1);
        wr(7, 7, 1);
        wr(19, 0, 8);
        wr(0, 25, 8);
        board[2][5] = 2'd0;
        do_select("sel_occ", 1'b1, 1, 9, 6);
        board[2][5] = 2'd2;
        do_select("sel_tie", 1'b1, 5, 2, 6);
        board[2][5] = 2'd3;
        board[9][1] = 2'd1;
        do_select("sel_small", 1'b1, 7, 7, 2);

        // Full board: noMove, previous move held
        fill_board(2'd1);
        do_select("sel_full", 1'b0, 7, 7, 2);
        check("full_moveValid", int'(bus.moveValid), 0);

        // Reset in the middle of a selection
        fill_board(2'd2);
        bus.enaSelect = 1'b1;
        tick();
        bus.enaSelect = 1'b0;
        repeat (100) tick();
        check("abort_enaRead_before", int'(bus.enaRead), 1);
        reset = 1'b0;
        #1;
        check("abort_enaRead",   int'(bus.enaRead),   0);
        check("abort_busy",      int'(bus.busy),      1);
        check("abort_moveX",     int'(bus.moveX),     0);
        check("abort_bestScore", int'(bus.bestScore), 0);
        repeat (2) tick();
        reset = 1'b1;
        wait_idle(n);
        check("abort_clear_cycles", n, 361);
        do_select("sel_after_abort", 1'b1, 0, 0, 0);

        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/move_select.md
# move_select

Downstream consumer of the line scanners' weight writes. Accumulates per-cell weights into a 19×19 score map, then on command scans the board for the highest-scoring empty cell and reports it as the next move. Sits between the horizontal/vertical/diagonal scanners and the move-output logic; it owns the score map, shares the board read port, and clears the map between turns.

## Interface
- `BRD`, 19: board width and height; the map holds BRD×BRD = 361 cells.
- `SW`, 8: score width; scores saturate at 2^SW−1 = 255.
- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-low (asserted at 0). One clock; reset is asynchronous and active-low.
- `enaWRITE` input 1: weight write strobe from the scanners.
- `XlocV` input 5: write column.
- `YlocV` input 5: write row.
- `weight` input 4: weight code, 0–8; 8 is the threat code T.
- `clearMap` input 1: start map clear, sampled in IDLE only.
- `enaSelect` input 1: start selection, sampled in IDLE only.
- `boardDataIN` input 2: board cell contents; 0 black, 1 white, 2 empty, 3 treated as occupied.
- `enaRead` output 1: board read request.
- `boardX` output 5: board read column.
- `boardY` output 5: board read row.
- `busy` output 1: high in every state except IDLE.
- `moveValid` output 1: one-cycle pulse when the chosen move is on `moveX`/`moveY`.
- `noMove` output 1: one-cycle pulse when no empty cell exists.
- `moveX` output 5: chosen column; held until the next selection.
- `moveY` output 5: chosen row; held until the next selection.
- `bestScore` output 8: score of the chosen cell; held with `moveX`/`moveY`.

## Operation
- **Reset values:**
  - Outputs: `enaRead` 0, `boardX`/`boardY` 0, `moveValid` 0, `noMove` 0, `moveX`/`moveY` 0, `bestScore` 0, `busy` 1.
  - Next state: CLEAR. The map array itself has no reset; CLEAR zeroes it.
- **FSM states:** CLEAR, IDLE, SEL_ADRS, SEL_READ, DONE.
- **CLEAR:**
  - Writes 0 to one cell per cycle at index `c` = 0..360, where address = y·19 + x (9 bits).
  - After index 360 the next state is IDLE.
  - Takes 361 cycles.
- **IDLE, accumulation:**
  - When `enaWRITE`=1 and `XlocV`≤18 and `YlocV`≤18, update cell [Y][X] in that same edge.
  - If `weight`=8: the score becomes 255.
  - Otherwise: score = min(score + weight, 255), computed 9 bits wide then clamped.
  - Coordinates above 18 are ignored.
- **IDLE, command priority:**
  - `clearMap` has priority over `enaSelect`.
  - An `enaWRITE` in the same cycle as either command is still applied; the command takes effect on the next state.
  - `enaWRITE` in any state other than IDLE is dropped silently. Upstream must hold off while `busy`=1.
- **Selection (SEL_ADRS / SEL_READ):**
  - Raster order: x fastest, then y, from (0,0) to (18,18).
  - SEL_ADRS: drive `boardX`=x, `boardY`=y, `enaRead`=1.
  - SEL_READ: sample `boardDataIN`. If it is 2 and (found=0 or score > best), latch best = score and bestX/Y = x/y, and set found=1.
  - Strict `>` means ties resolve to the earliest cell in raster order.
  - After the SEL_READ of (18,18) the next state is DONE.
- **DONE:**
  - `enaRead` goes to 0.
  - If found=1: pulse `moveValid`=1 and load `moveX`/`moveY`/`bestScore`.
  - If found=0: pulse `noMove`=1; `moveX`/`moveY`/`bestScore` keep their old values.
  - Next state is IDLE.
- **Map preservation:** the score map is not modified by selection. The controller issues `clearMap` between turns.

## Timing
- Accumulate latency is 1 cycle; the new score is readable on the following edge.
- Back-to-back `enaWRITE`s to the same cell accumulate correctly on every edge.
- `clearMap` sampled at edge E: `busy`=1 from E, and IDLE is re-entered at E+361.
- `enaSelect` sampled at edge E: cells are visited at 2 cycles each (722 cycles); `moveValid`/`noMove` is high for the cycle after edge E+723; IDLE at E+724.
- `enaRead`=1 throughout selection (SEL_ADRS and SEL_READ). The board is valid at the SEL_READ sample, i.e. 1-cycle board latency.
- Asserting `reset` mid-operation aborts immediately: outputs go to their reset values and a fresh CLEAR follows reset release.
- `clearMap` and `enaSelect` pulses while `busy`=1 are ignored.

## Test plan
- **Reset:** pulse `reset`=0 then release → `busy`=1 for 361 cycles, then 0. Each cell then reads 0, checked via a select on an all-empty board: move (0,0), `bestScore`=0.
- **Accumulation and saturation:** write weight 5 to (3,4) sixty times → score 255, not wrapped. Select on an empty board → `moveX`=3, `moveY`=4, `bestScore`=255.
- **Threat code:** write 2 then 8 then 3 to (10,7) → 255. Write 7 to (0,0) → 7. Select → (10,7), 255.
- **Tie and occupancy:** write 6 to (5,2) and to (1,9); mark (5,2) occupied (board=0) → move (1,9). Then mark (1,9) empty-free … with both empty → (5,2), the earlier raster cell.
- **Full board:** all cells `boardDataIN`=1 → `noMove` pulses after 723 cycles, `moveValid` stays 0, `moveX`/`moveY` unchanged.
- **Busy drop and reset abort:** `enaWRITE` to (2,2) during CLEAR → ignored (score 0 afterwards). Assert `reset` at cycle 100 of a selection → `enaRead`=0 and `moveValid` never pulses; CLEAR restarts.
